triangle_fetch: RTL and testbench
=================================

Name: triangle_fetch

Overview:
- Primitive-assembly stage directly downstream of the 48-bit edge (index-triple) buffer.
- On START, walks a run of edge entries and, for each entry, reads the three vertex indices (i0 = bits 15:0, i1 = 31:16, i2 = 47:32).
- Fetches the three vertex words from the vertex buffer and presents each assembled triangle to the rasteriser over a valid/ready handshake.
- Owns read port B of the edge buffer and one read port of the vertex buffer; both are synchronous-read BRAMs with 1-cycle latency.

Parameters:
- DEPTH, 1024, edge buffer entries; EAW = $clog2(DEPTH).
- DW, 48, edge entry width; must be 48.
- VW, 48, vertex word width (opaque payload, passed through unchanged).
- VAW, 16, vertex address width (matches index field width).

Ports:
- CLK  in  1  single clock; all logic on rising edge.
- RST_N  in  1  reset, asynchronous assert, active-low.
- START  in  1  1-cycle request; sampled only in IDLE.
- BASE_EDGE  in  EAW  first edge entry; sampled with START.
- EDGE_COUNT  in  EAW+1  number of edges, 0..DEPTH; sampled with START.
- VTX_COUNT  in  VAW+1  valid vertex count for range check; sampled with START.
- BUSY  out  1  high whenever not IDLE.
- DONE  out  1  1-cycle pulse at end of run.
- IDX_ERR  out  1  sticky; set on any out-of-range index; cleared by next accepted START.
- EDGE_ADDR  out  EAW  edge buffer read address.
- EDGE_Q  in  DW  edge buffer read data, valid the cycle after EDGE_ADDR.
- VTX_ADDR  out  VAW  vertex buffer read address.
- VTX_Q  in  VW  vertex read data, valid the cycle after VTX_ADDR.
- TRI_VALID  out  1  triangle valid.
- TRI_READY  in  1  downstream accept.
- TRI_V0/TRI_V1/TRI_V2  out  VW each  vertex payloads.
- TRI_LAST  out  1  qualifies the triangle from the final edge of the run.

Behaviour:
- Reset (async, RST_N=0): state IDLE; BUSY, DONE, IDX_ERR, TRI_VALID, TRI_LAST = 0; TRI_V* = 0; EDGE_ADDR = 0; VTX_ADDR = 0; internal pointer and counter = 0.
- Reset mid-run: run is abandoned immediately, no DONE is generated, and a held triangle is dropped.
- States: IDLE, E_REQ, E_CAP, V0_REQ, V1_REQ, V2_REQ, V_CAP, OUT, FIN.
- IDLE:
  - START=1 latches ptr=BASE_EDGE, remaining=EDGE_COUNT and VTX_COUNT, and clears IDX_ERR.
  - Goes to FIN if EDGE_COUNT=0, else to E_REQ.
  - START outside IDLE is ignored.
- E_REQ: EDGE_ADDR=ptr.
- E_CAP:
  - Register i0/i1/i2 from EDGE_QW.
  - If any index >= latched VTX_COUNT: set IDX_ERR, drop the edge, and go to the advance step.
  - Otherwise go to V0_REQ.
- V0_REQ: VTX_ADDR=i0.
- V1_REQ: VTX_ADDR=i1; capture VTX_Q into TRI_V0.
- V2_REQ: VTX_ADDR=i2; capture VTX_Q into TRI_V1.
- V_CAP:
  - Capture VTX_Q into TRI_V2.
  - Set TRI_VALID=1 and TRI_LAST=(remaining==1).
  - Go to OUT.
- OUT:
  - Hold TRI_V*, TRI_VALID and TRI_LAST stable while TRI_READY=0.
  - On TRI_VALID&&TRI_READY: TRI_VALID and TRI_LAST drop next cycle, then advance.
- Advance:
  - ptr = (ptr+1) mod DEPTH, so BASE_EDGE+EDGE_COUNT past DEPTH-1 wraps to 0.
  - remaining decrements.
  - If remaining becomes 0 go to FIN, else go to E_REQ.
- FIN: DONE=1 for exactly one cycle, then IDLE. BUSY drops in the same cycle DONE drops.
- Latency and throughput:
  - First TRI_VALID appears 6 cycles after START is sampled.
  - Steady-state rate is one triangle per 7 cycles when TRI_READY is held high.
- If the final edge is dropped for a range error, no TRI_LAST is emitted; DONE still pulses.
- Degenerate triangles (repeated indices) are not filtered and pass through.
- EDGE_ADDR and VTX_ADDR hold their last value outside their request states.

Test Plan:
- Edge[5]=idx(0,1,2), V[0..2]=0xA,0xB,0xC; START BASE=5, COUNT=1, VTX_COUNT=3, TRI_READY=1 -> TRI_VALID 6 cycles after START; V0/V1/V2 = 0xA/0xB/0xC; TRI_LAST=1; DONE pulses 2 cycles after the handshake; IDX_ERR=0.
- BASE=1022, COUNT=4 -> edges 1022, 1023, 0, 1 fetched in order; TRI_LAST only on the 4th triangle.
- TRI_READY low for 10 cycles on the 2nd triangle -> payload and TRI_VALID held stable; no extra edge reads; all 3 triangles delivered.
- Edge with i1=7, VTX_COUNT=5, COUNT=2 (bad edge first) -> IDX_ERR=1 and sticky; only the 2nd triangle is emitted (TRI_LAST=1); DONE pulses; next START clears IDX_ERR.
- COUNT=0 -> no TRI_VALID; DONE pulses 2 cycles after START; START asserted while BUSY during a 3-edge run is ignored (exactly 3 triangles).
- RST_N low during OUT with TRI_VALID=1 -> TRI_VALID, BUSY = 0 immediately; no DONE; a fresh START after release runs normally.

Source files
------------

// File: rtl/triangle_fetch.sv
// triangle_fetch: walks a run of edge-buffer index triples, fetches the three vertices of each
// and hands assembled triangles to the rasteriser over valid/ready.
module triangle_fetch #(
  parameter int DEPTH = 1024,
  parameter int DW = 48,
  parameter int VW = 48,
  parameter int VAW = 16,
  localparam int EAW = $clog2(DEPTH)
) (
  input  logic           clk_i,
  input  logic           rst_n_i,
  input  logic           start_i,
  input  logic [EAW-1:0] base_edge_i,
  input  logic [EAW:0]   edge_count_i,
  input  logic [VAW:0]   vtx_count_i,
  output logic           busy_o,
  output logic           done_o,
  output logic           idx_err_o,
  output logic [EAW-1:0] edge_addr_o,
  input  logic [DW-1:0]  edge_q_i,
  output logic [VAW-1:0] vtx_addr_o,
  input  logic [VW-1:0]  vtx_q_i,
  output logic           tri_valid_o,
  input  logic           tri_ready_i,
  output logic [VW-1:0]  tri_v0_o,
  output logic [VW-1:0]  tri_v1_o,
  output logic [VW-1:0]  tri_v2_o,
  output logic           tri_last_o
);
  typedef enum logic [3:0] {IDLE, E_REQ, E_CAP, V0_REQ, V1_REQ, V2_REQ, V_CAP, OUT, FIN} state_e;
  state_e state_q, state_d;
  logic [EAW-1:0] ptr_q, ptr_d, edge_addr_q;
  logic [EAW:0] rem_q;
  logic [VAW:0] vcnt_q;
  logic [VAW-1:0] i1_q, i2_q, vtx_addr_q, e0, e1, e2;
  logic [VW-1:0] v0_q, v1_q, v2_q;
  logic valid_q, last_q, err_q, done_q;
  logic accept, bad, adv, last;
  assign e0 = edge_q_i[VAW-1:0];
  assign e1 = edge_q_i[2*VAW-1:VAW];
  assign e2 = edge_q_i[3*VAW-1:2*VAW];
  assign accept = state_q == IDLE && start_i;
  assign bad = {1'b0, e0} >= vcnt_q || {1'b0, e1} >= vcnt_q || {1'b0, e2} >= vcnt_q;
  assign adv = (state_q == E_CAP && bad) || (state_q == OUT && tri_ready_i);
  assign last = rem_q == (EAW+1)'(1);
  assign ptr_d = accept ? base_edge_i :
                 adv ? (ptr_q == EAW'(DEPTH-1) ? '0 : ptr_q + EAW'(1)) : ptr_q;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = !start_i ? IDLE : edge_count_i == '0 ? FIN : E_REQ;
      E_REQ:   state_d = E_CAP;
      E_CAP:   state_d = !bad ? V0_REQ : last ? FIN : E_REQ;
      V0_REQ:  state_d = V1_REQ;
      V1_REQ:  state_d = V2_REQ;
      V2_REQ:  state_d = V_CAP;
      V_CAP:   state_d = OUT;
      OUT:     state_d = !tri_ready_i ? OUT : last ? FIN : E_REQ;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      rem_q       <= '0;
      vcnt_q      <= '0;
      i1_q        <= '0;
      i2_q        <= '0;
      edge_addr_q <= '0;
      vtx_addr_q  <= '0;
      v0_q        <= '0;
      v1_q        <= '0;
      v2_q        <= '0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      done_q  <= state_q == FIN;
      if (state_d == E_REQ) edge_addr_q <= ptr_d;
      if (accept) begin
        rem_q  <= edge_count_i;
        vcnt_q <= vtx_count_i;
      end else if (adv) rem_q <= rem_q - (EAW+1)'(1);
      if (accept) err_q <= 1'b0;
      else if (state_q == E_CAP && bad) err_q <= 1'b1;
      // vertex addresses are registered one state ahead so each read lands in the next state
      if (state_q == E_CAP) begin
        i1_q <= e1;
        i2_q <= e2;
      end
      if (state_d == V0_REQ) vtx_addr_q <= e0;
      if (state_q == V0_REQ) vtx_addr_q <= i1_q;
      if (state_q == V1_REQ) begin
        vtx_addr_q <= i2_q;
        v0_q       <= vtx_q_i;
      end
      if (state_q == V2_REQ) v1_q <= vtx_q_i;
      if (state_q == V_CAP) begin
        v2_q    <= vtx_q_i;
        valid_q <= 1'b1;
        last_q  <= last;
      end else if (state_q == OUT && tri_ready_i) begin
        valid_q <= 1'b0;
        last_q  <= 1'b0;
      end
    end
  end
  assign busy_o      = state_q != IDLE || done_q;
  assign done_o      = done_q;
  assign idx_err_o   = err_q;
  assign edge_addr_o = edge_addr_q;
  assign vtx_addr_o  = vtx_addr_q;
  assign tri_valid_o = valid_q;
  assign tri_last_o  = last_q;
  assign tri_v0_o    = v0_q;
  assign tri_v1_o    = v1_q;
  assign tri_v2_o    = v2_q;
endmodule

// File: tb/tb_triangle_fetch.sv
// tb_triangle_fetch: drives runs against BRAM models and checks triangles against a per-edge reference model
module tb_triangle_fetch;
  localparam int DEPTH = 1024;
  localparam int EAW = 10;
  localparam int VAW = 16;
  typedef struct packed {logic [47:0] v0; logic [47:0] v1; logic [47:0] v2; logic last;} tri_t;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, ready = 1'b0;
  logic [EAW-1:0] base = '0;
  logic [EAW:0] ecount = '0;
  logic [VAW:0] vcount = '0;
  logic busy, done, idx_err, tri_valid, tri_last;
  logic [EAW-1:0] edge_addr;
  logic [VAW-1:0] vtx_addr;
  logic [47:0] edge_q, vtx_q, tri_v0, tri_v1, tri_v2;
  logic [47:0] edge_mem [DEPTH];
  logic [47:0] vtx_mem [256];
  int checks = 0, errors = 0, cyc = 0, done_cnt = 0, done_cyc = 0, run_d0 = 0, s_cyc = 0;
  tri_t got[$], exp_q[$];
  int hs_cyc[$];
  logic [EAW-1:0] ea_log[$];
  logic [EAW-1:0] last_ea = '0;
  bit exp_err;

  triangle_fetch dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .base_edge_i(base), .edge_count_i(ecount),
    .vtx_count_i(vcount), .busy_o(busy), .done_o(done), .idx_err_o(idx_err), .edge_addr_o(edge_addr),
    .edge_q_i(edge_q), .vtx_addr_o(vtx_addr), .vtx_q_i(vtx_q), .tri_valid_o(tri_valid),
    .tri_ready_i(ready), .tri_v0_o(tri_v0), .tri_v1_o(tri_v1), .tri_v2_o(tri_v2), .tri_last_o(tri_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) begin
    edge_q <= edge_mem[edge_addr];
    vtx_q  <= vtx_mem[vtx_addr[7:0]];
    cyc    <= cyc + 1;
  end
  always @(negedge clk) begin
    if (tri_valid && ready) begin
      got.push_back({tri_v0, tri_v1, tri_v2, tri_last});
      hs_cyc.push_back(cyc);
    end
    if (done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
    if (edge_addr !== last_ea) begin
      ea_log.push_back(edge_addr);
      last_ea = edge_addr;
    end
  end

  // Reference: every edge of the run in order; an out-of-range index drops the edge and flags the error
  task automatic build_exp(int b, int n, int vc);
    logic [47:0] e;
    exp_q.delete();
    exp_err = 0;
    for (int k = 0; k < n; k++) begin
      e = edge_mem[(b + k) % DEPTH];
      if (int'(e[15:0]) >= vc || int'(e[31:16]) >= vc || int'(e[47:32]) >= vc) exp_err = 1;
      else exp_q.push_back({vtx_mem[e[7:0]], vtx_mem[e[23:16]], vtx_mem[e[39:32]], k == n - 1});
    end
  endtask

  task automatic fill_edges(int b, int n, int vc, int bad_pct);
    logic [15:0] ix [3];
    for (int k = 0; k < n; k++) begin
      for (int j = 0; j < 3; j++) ix[j] = 16'($urandom_range(0, vc - 1));
      if (int'($urandom_range(0, 99)) < bad_pct) ix[$urandom_range(0, 2)] = 16'(vc + int'($urandom_range(0, 500)));
      edge_mem[(b + k) % DEPTH] = {ix[2], ix[1], ix[0]};
    end
  endtask

  task automatic start_run(int b, int n, int vc);
    build_exp(b, n, vc);
    got.delete();
    hs_cyc.delete();
    ea_log.delete();
    run_d0 = done_cnt;
    @(posedge clk); #1;
    base = EAW'(b);
    ecount = (EAW+1)'(n);
    vcount = (VAW+1)'(vc);
    start = 1'b1;
    s_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(int budget, bit rnd);
    for (int c = 0; c < budget && done_cnt == run_d0; c++) begin
      @(posedge clk); #1;
      if (rnd) ready = 1'($urandom_range(0, 1));
    end
    ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic cmp_run(string tag);
    checks++;
    if (done_cnt - run_d0 !== 1) begin errors++; $display("FAIL %s done_pulses got %0d want 1", tag, done_cnt - run_d0); end
    checks++;
    if (got.size() !== exp_q.size()) begin errors++; $display("FAIL %s tri_count got %0d want %0d", tag, got.size(), exp_q.size()); end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got[i] !== exp_q[i]) begin errors++; $display("FAIL %s tri[%0d] got %h want %h", tag, i, got[i], exp_q[i]); end
    end
    checks++;
    if (idx_err !== exp_err) begin errors++; $display("FAIL %s idx_err got %b want %b", tag, idx_err, exp_err); end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, idx_err, tri_valid, tri_last} !== 5'b0) begin errors++; $display("FAIL reset_flags got %b want 00000", {busy, done, idx_err, tri_valid, tri_last}); end
    checks++;
    if ({edge_addr, vtx_addr} !== '0) begin errors++; $display("FAIL reset_addr got %h/%h want 0/0", edge_addr, vtx_addr); end
    checks++;
    if ({tri_v0, tri_v1, tri_v2} !== '0) begin errors++; $display("FAIL reset_payload got %h want 0", {tri_v0, tri_v1, tri_v2}); end
    rst_n = 1'b1;
  endtask

  task automatic test_single;
    vtx_mem[0] = 48'hA; vtx_mem[1] = 48'hB; vtx_mem[2] = 48'hC;
    edge_mem[5] = {16'd2, 16'd1, 16'd0};
    ready = 1'b1;
    start_run(5, 1, 3);
    wait_done(60, 0);
    cmp_run("single");
    checks++;
    if (got.size() != 1 || got[0] !== {48'hA, 48'hB, 48'hC, 1'b1}) begin errors++; $display("FAIL single_payload got %0d tris want A/B/C last", got.size()); end
    checks++;
    if (hs_cyc.size() != 1 || hs_cyc[0] !== s_cyc + 7) begin errors++; $display("FAIL single_latency got %0d want %0d", hs_cyc.size() ? hs_cyc[0] - s_cyc : -1, 7); end
    checks++;
    if (hs_cyc.size() != 1 || done_cyc !== hs_cyc[0] + 2) begin errors++; $display("FAIL single_done_cycle got %0d want handshake+2", done_cyc); end
  endtask

  task automatic test_wrap;
    fill_edges(1022, 4, 200, 0);
    start_run(1022, 4, 200);
    wait_done(100, 0);
    cmp_run("wrap");
    checks++;
    if (ea_log.size() !== 4) begin errors++; $display("FAIL wrap_edge_reads got %0d want 4", ea_log.size()); end
    for (int i = 0; i < 4 && i < ea_log.size(); i++) begin
      checks++;
      if (ea_log[i] !== EAW'((1022 + i) % DEPTH)) begin errors++; $display("FAIL wrap_addr[%0d] got %0d want %0d", i, ea_log[i], (1022 + i) % DEPTH); end
    end
    checks++;
    if (hs_cyc.size() == 4 && hs_cyc[1] - hs_cyc[0] !== 7) begin errors++; $display("FAIL wrap_rate got %0d want 7", hs_cyc[1] - hs_cyc[0]); end
  endtask

  task automatic test_stall;
    int n = 0, bad = 0;
    logic [144:0] snap;
    logic [EAW-1:0] ea;
    fill_edges(100, 3, 64, 0);
    ready = 1'b0;
    start_run(100, 3, 64);
    for (int c = 0; c < 300 && done_cnt == run_d0; c++) begin
      @(negedge clk);
      if (tri_valid && !ready) begin
        n++;
        if (n == 2) begin
          snap = {tri_v0, tri_v1, tri_v2, tri_last};
          ea = edge_addr;
          repeat (10) begin
            @(negedge clk);
            if (tri_valid !== 1'b1 || {tri_v0, tri_v1, tri_v2, tri_last} !== snap || edge_addr !== ea) bad++;
          end
        end
        @(posedge clk); #1 ready = 1'b1;
        @(posedge clk); #1 ready = 1'b0;
      end
    end
    ready = 1'b1;
    @(negedge clk);
    cmp_run("stall");
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL stall_hold got %0d unstable cycles want 0", bad); end
  endtask

  task automatic test_idx_err;
    vtx_mem[3] = 48'h333; vtx_mem[4] = 48'h444;
    edge_mem[200] = {16'd0, 16'd7, 16'd1};
    edge_mem[201] = {16'd2, 16'd4, 16'd3};
    start_run(200, 2, 5);
    wait_done(100, 0);
    cmp_run("idx_err");
    checks++;
    if (got.size() != 1 || got[0] !== {48'h333, 48'h444, 48'hC, 1'b1}) begin errors++; $display("FAIL idx_err_tri got %0d tris want V3/V4/V2 last", got.size()); end
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (idx_err !== 1'b1) begin errors++; $display("FAIL idx_err_sticky got %b want 1", idx_err); end
    start_run(201, 1, 5);
    checks++;
    if (idx_err !== 1'b0) begin errors++; $display("FAIL idx_err_clear got %b want 0", idx_err); end
    wait_done(60, 0);
    cmp_run("idx_clear_run");
    edge_mem[300] = {16'd1, 16'd1, 16'd1};
    edge_mem[301] = {16'd9, 16'd0, 16'd0};
    start_run(300, 2, 5);
    wait_done(100, 0);
    cmp_run("bad_last");
    checks++;
    if (got.size() != 1 || got[0].last !== 1'b0) begin errors++; $display("FAIL bad_last_flag got %0d tris want 1 without last", got.size()); end
  endtask

  task automatic test_zero_and_ignore;
    start_run(17, 0, 10);
    wait_done(20, 0);
    cmp_run("zero");
    checks++;
    if (done_cyc !== s_cyc + 2) begin errors++; $display("FAIL zero_done_cycle got %0d want %0d", done_cyc - s_cyc, 2); end
    fill_edges(400, 3, 100, 0);
    fill_edges(600, 5, 100, 0);
    start_run(400, 3, 100);
    repeat (9) @(posedge clk);
    #1;
    base = EAW'(600); ecount = 11'd5; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(100, 0);
    cmp_run("ignore");
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL ignore_idle got busy %b want 0", busy); end
  endtask

  task automatic test_reset_mid;
    int d0;
    ready = 1'b0;
    start_run(5, 1, 3);
    for (int c = 0; c < 30 && !tri_valid; c++) @(negedge clk);
    checks++;
    if (tri_valid !== 1'b1) begin errors++; $display("FAIL rst_mid_reach got valid %b want 1", tri_valid); end
    d0 = done_cnt;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({tri_valid, busy, tri_last} !== 3'b0) begin errors++; $display("FAIL rst_mid_clear got %b want 000", {tri_valid, busy, tri_last}); end
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    checks++;
    if (done_cnt !== d0) begin errors++; $display("FAIL rst_mid_no_done got %0d pulses want 0", done_cnt - d0); end
    ready = 1'b1;
    start_run(5, 1, 3);
    wait_done(60, 0);
    cmp_run("after_reset");
  endtask

  task automatic test_random;
    int b, n, vc;
    for (int r = 0; r < 8; r++) begin
      b = $urandom_range(0, DEPTH - 1);
      n = $urandom_range(1, 6);
      vc = $urandom_range(1, 256);
      fill_edges(b, n, vc, 25);
      start_run(b, n, vc);
      wait_done(n * 40 + 40, 1);
      cmp_run("random");
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) vtx_mem[i] = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
    for (int i = 0; i < DEPTH; i++) edge_mem[i] = '0;
    test_reset;
    test_single;
    test_wrap;
    test_stall;
    test_idx_err;
    test_zero_and_ignore;
    test_reset_mid;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
